// File: rtl/gf_pkg.sv
// Shared constants and controller state encoding for the GF(2^Size) divider.
// Defaults describe the AES field GF(2^8) with x^8+x^4+x^3+x+1.
package gf_pkg;
   localparam int GF_SIZE = 8;
   localparam logic [GF_SIZE:0] GF_POLY = 9'b100011011;
   localparam int GF_ROUND_W = $clog2(GF_SIZE);

   typedef enum logic [2:0] {
      IDLE,
      SQR,
      ACC,
      FINAL,
      DONE
   } gf_state_e;
endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^Size) multiply: carry-less product reduced modulo Poly.
// Horner form, MSB of b first, so each step is one xtime plus a conditional add.
module gf_mul
   import gf_pkg::*;
#(
   parameter int               Size = GF_SIZE,
   parameter logic [Size:0]    Poly = GF_POLY
) (
   input  logic [Size-1:0] a_i,
   input  logic [Size-1:0] b_i,
   output logic [Size-1:0] p_o
);

   logic [Size-1:0] acc;

   always_comb begin
      acc = '0;
      for (int i = Size - 1; i >= 0; i--) begin
         acc = {acc[Size-2:0], 1'b0}
             ^ (acc[Size-1] ? Poly[Size-1:0] : {Size{1'b0}})
             ^ (b_i[i] ? a_i : {Size{1'b0}});
      end
   end

   assign p_o = acc;

endmodule

// File: rtl/gf_divider_ctrl.sv
// Sequential GF(2^Size) divider: one shared multiplier computes divisor^(2^Size-2)
// by square-and-multiply, then multiplies by the dividend.
module gf_divider_ctrl
   import gf_pkg::*;
#(
   parameter int               Size = GF_SIZE,
   parameter logic [Size:0]    Poly = GF_POLY
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [Size-1:0] dividend,
   input  logic [Size-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [Size-1:0] quotient,
   output logic            div_by_zero
);

   localparam int RoundW = (Size > 2) ? $clog2(Size) : 1;
   localparam logic [RoundW-1:0] LastRound = RoundW'(Size - 2);

   gf_state_e         state_q, state_d;
   logic [Size-1:0]   a_q, a_d;
   logic [Size-1:0]   p_q, p_d;
   logic [Size-1:0]   r_q, r_d;
   logic [RoundW-1:0] round_q, round_d;
   logic [Size-1:0]   quot_q, quot_d;
   logic              dbz_q, dbz_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [Size-1:0]   op_x, op_y, prod;

   gf_mul #(
      .Size (Size),
      .Poly (Poly)
   ) u_mul (
      .a_i (op_x),
      .b_i (op_y),
      .p_o (prod)
   );

   always_comb begin
      op_x = '0;
      op_y = '0;
      case (state_q)
         SQR:     begin op_x = p_q; op_y = p_q; end
         ACC:     begin op_x = r_q; op_y = p_q; end
         FINAL:   begin op_x = a_q; op_y = r_q; end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      p_d     = p_q;
      r_d     = r_q;
      round_d = round_q;
      quot_d  = quot_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  quot_d  = '0;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  a_d     = dividend;
                  p_d     = divisor;
                  r_d     = Size'(1);
                  round_d = '0;
                  dbz_d   = 1'b0;
                  state_d = SQR;
               end
            end
         end
         SQR: begin
            p_d     = prod;
            state_d = ACC;
         end
         ACC: begin
            r_d     = prod;
            round_d = round_q + RoundW'(1);
            state_d = (round_q == LastRound) ? FINAL : SQR;
         end
         FINAL: begin
            quot_d  = prod;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status flags are registered from the next state so they align with it.
   assign busy_d = (state_d != IDLE);
   assign done_d = (state_d == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         p_q     <= '0;
         r_q     <= '0;
         round_q <= '0;
         quot_q  <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         p_q     <= p_d;
         r_q     <= r_d;
         round_q <= round_d;
         quot_q  <= quot_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_gf_divider_ctrl.sv
// Self-checking bench for gf_divider_ctrl: directed cases, full inverse sweep and
// random divisions against a brute-force field-inverse reference.
module tb_gf_divider_ctrl;

   localparam logic [8:0] POLY = 9'b100011011;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic       div_by_zero;

   int n_tests;
   int n_fail;

   gf_divider_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Schoolbook polynomial product, then long-division reduction by POLY.
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) prod = prod ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (prod[i]) prod = prod ^ (16'(POLY) << (i - 8));
      return prod[7:0];
   endfunction

   function automatic logic [7:0] ref_div(input logic [7:0] dd, input logic [7:0] dv);
      logic [7:0] inv;
      inv = '0;
      if (dv == 8'h00) return 8'h00;
      for (int x = 1; x < 256; x++)
         if (ref_mul(dv, 8'(x)) == 8'h01) inv = 8'(x);
      return ref_mul(dd, inv);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Starts at a negedge in IDLE, returns at the negedge of the cycle after done.
   task automatic run_div(input logic [7:0] dd, input logic [7:0] dv, input bit pulse,
                          output logic [7:0] q_out);
      int         c;
      int         exp_lat;
      logic [7:0] exp_q;
      exp_q   = ref_div(dd, dv);
      exp_lat = (dv == 8'h00) ? 1 : 16;
      start    = 1'b1;
      dividend = dd;
      divisor  = dv;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      c = 1;
      check("busy_c1", busy, 1);
      while (!done && c < 40) begin
         if (pulse && (c == 3 || c == 10)) begin
            start    = 1'b1;
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         c++;
      end
      start = 1'b0;
      check("latency", c, exp_lat);
      check("done", done, 1);
      check("quotient", quotient, exp_q);
      check("div_by_zero", div_by_zero, (dv == 8'h00));
      q_out = quotient;
      $display("[TB] div %02h/%02h -> q=%02h dbz=%0d lat=%0d", dd, dv, quotient, div_by_zero, c);
      @(negedge clk);
      check("busy_after", busy, 0);
      check("done_after", done, 0);
      check("q_hold", quotient, exp_q);
   endtask

   initial begin
      logic [7:0] q;
      int         c;
      int         dcount;
      logic [7:0] rd, rv;

      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_quotient", quotient, 0);
      check("rst_dbz", div_by_zero, 0);
      rst = 1'b0;
      @(negedge clk);

      run_div(8'h01, 8'h53, 1'b0, q);
      check("inv_53", q, 8'hCA);

      // Reset in the middle of an ACC cycle discards the operation.
      start    = 1'b1;
      dividend = 8'h01;
      divisor  = 8'h53;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_quotient", quotient, 0);
      check("midrst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) dcount++;
         if (busy) dcount++;
      end
      check("midrst_no_done", dcount, 0);
      $display("[TB] reset during ACC, quiet cycles checked");

      run_div(8'hC1, 8'h83, 1'b1, q);
      check("div_c1_83", q, 8'h57);
      run_div(8'h5A, 8'h00, 1'b0, q);
      run_div(8'h01, 8'h01, 1'b0, q);
      run_div(8'h00, 8'h1F, 1'b0, q);

      // Back-to-back with start held high.
      start    = 1'b1;
      dividend = 8'h57;
      divisor  = 8'h01;
      @(posedge clk);
      @(negedge clk);
      dividend = 8'h00;
      divisor  = 8'h53;
      c = 1;
      while (!done && c < 40) begin
         @(negedge clk);
         c++;
      end
      check("b2b_lat1", c, 16);
      check("b2b_q1", quotient, 8'h57);
      $display("[TB] b2b div 57/01 -> q=%02h lat=%0d", quotient, c);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!done && c < 40);
      start = 1'b0;
      check("b2b_gap", c, 17);
      check("b2b_q2", quotient, 8'h00);
      check("b2b_dbz2", div_by_zero, 0);
      $display("[TB] b2b div 00/53 -> q=%02h gap=%0d", quotient, c);
      @(negedge clk);
      check("b2b_idle", busy, 0);

      for (int dv = 1; dv < 256; dv++) begin
         run_div(8'h01, 8'(dv), 1'b0, q);
         check("sweep_inv", ref_mul(8'(dv), q), 8'h01);
      end

      for (int i = 0; i < 40; i++) begin
         rd = 8'($urandom);
         rv = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
         run_div(rd, rv, 1'($urandom), q);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
